// File: rtl/reg_bank_param.sv
// Parametrised register bank: two read ports (port 1 bank-selected), one acked write port, tap port, clear sweep FSM.
// Optional same-cycle write-to-read forwarding when REG_BANK_BYPASS_EN is defined.
module reg_bank_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int TAP_IDX  = 3,
  parameter int ZERO_REG = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-2:0] rd_addr1,
  input  logic              bank_sel,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] tap_data
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_acc;
  logic              wr_store;
  logic              sweep_last;
  logic              sweep_done;

  assign wr_acc     = wr_en && (state == IDLE);
  // Writes to a hardwired zero register are acked but never stored.
  assign wr_store   = wr_acc && !((ZERO_REG != 0) && (wr_addr == '0));
  assign sweep_last = (ptr == ADDR_W'(DEPTH - 1));
  assign busy       = (state == CLEAR);

  always_comb begin
    state_nxt  = state;
    sweep_done = 1'b0;
    case (state)
      IDLE:  if (clr_req) state_nxt = CLEAR;
      CLEAR: if (sweep_last) begin
               state_nxt  = IDLE;
               sweep_done = 1'b1;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pointer saturates at DEPTH-1 and is reloaded with 0 whenever idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                          ptr <= '0;
    else if (state == CLEAR && !sweep_last) ptr <= ptr + 1'b1;
    else                                 ptr <= '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wr_store)        regs[wr_addr] <= wr_data;
      if (state == CLEAR)  regs[ptr]     <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ack   <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      wr_ack   <= wr_acc;
      clr_done <= sweep_done;
    end
  end

  logic [ADDR_W-1:0] rd_idx [3];
  logic [DATA_W-1:0] rd_val [3];

  assign rd_idx[0] = {bank_sel, rd_addr1};
  assign rd_idx[1] = rd_addr2;
  assign rd_idx[2] = ADDR_W'(TAP_IDX);

  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_val[p] = regs[rd_idx[p]];
`ifdef REG_BANK_BYPASS_EN
      if (wr_acc && (rd_idx[p] == wr_addr)) rd_val[p] = wr_data;
`endif
      if ((ZERO_REG != 0) && (rd_idx[p] == '0)) rd_val[p] = '0;
    end
  end

  assign rd_data1 = rd_val[0];
  assign rd_data2 = rd_val[1];
  assign tap_data = rd_val[2];

endmodule

// File: doc/reg_bank_param.md
Name: reg_bank_param

Overview:
- Parametrised successor to the processor's 8x8 register bank: DEPTH registers of DATA_W bits, two read ports, one write port and a fixed tap port.
- Adds a bank-select mode on read port 1, an acknowledged synchronous write, and a multi-cycle clear sweep FSM with a busy flag.
- Sits between decode and the ULA datapath. The tap port drives the display/debug path.

Parameters:
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- TAP_IDX, 3, index of the register mirrored on tap_data
- ZERO_REG, 0, 1 = register 0 is hardwired to zero

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset
- rd_addr1  input  ADDR_W-1  read port 1 index within the selected half
- bank_sel  input  1  read port 1 half select; effective address = {bank_sel, rd_addr1}
- rd_addr2  input  ADDR_W  read port 2 full address
- wr_en  input  1  write request
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- wr_ack  output  1  one-cycle pulse: the write was accepted
- clr_req  input  1  start clear sweep
- busy  output  1  clear sweep in progress
- clr_done  output  1  one-cycle pulse when the sweep completes
- rd_data1  output  DATA_W  data at {bank_sel, rd_addr1}
- rd_data2  output  DATA_W  data at rd_addr2
- tap_data  output  DATA_W  data in register TAP_IDX

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers cleared to 0; FSM to IDLE; sweep pointer cleared to 0.
  - busy=0, wr_ack=0, clr_done=0.
  - Read outputs therefore show 0.
- Reads:
  - Combinational from the array, zero latency.
  - A write is visible on the read ports the cycle after the accepting edge.
- Write acceptance:
  - A write is accepted at a rising edge when wr_en=1 and the FSM is in IDLE.
  - The register updates at that edge; wr_ack=1 for the following cycle only.
  - A wr_en asserted while busy is dropped: no update, no ack. The requester must retry.
- ZERO_REG=1:
  - Writes to address 0 are accepted and acked but do not change the array.
  - Reads of address 0 return 0.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clr_req=1. The sweep pointer is loaded with 0.
  - CLEAR: busy=1. Each cycle, the register at the pointer is zeroed and the pointer increments.
  - When the pointer reaches DEPTH-1, that register is zeroed and the FSM returns to IDLE. clr_done=1 for one cycle and busy drops in the same cycle.
  - The sweep takes exactly DEPTH cycles in CLEAR.
- Simultaneous events:
  - wr_en and clr_req in IDLE on the same edge: the write is accepted and acked, CLEAR starts next cycle, and the sweep later zeroes the written register.
  - clr_req while in CLEAR: ignored; the sweep is not restarted.
- Reads during CLEAR are permitted. Registers not yet swept still return their old value.
- Reset mid-sweep: the array is fully cleared immediately, the FSM returns to IDLE, and clr_done is not pulsed.
- Width rules:
  - No arithmetic on data.
  - The pointer is ADDR_W bits; it must not wrap past DEPTH-1 into a second pass.

Optional Feature:
- Macro: REG_BANK_BYPASS_EN.
- Defined: when a write is accepted in the current cycle and a read port's effective address equals wr_addr, that port returns wr_data combinationally in the same cycle. This also applies to tap_data when wr_addr==TAP_IDX.
- With ZERO_REG=1, address 0 is never bypassed.
- Undefined: no forwarding; reads return the stored value, one cycle behind the write.

Test Plan:
- Reset release, then read all addresses on both ports -> rd_data1/rd_data2/tap_data=0; busy=0, wr_ack=0.
- Write 8'hA5 to addr 3 -> wr_ack=1 next cycle only; tap_data=8'hA5. Then rd_addr1=2'b11 with bank_sel=0 -> rd_data1=8'hA5.
- Write 8'h3C to addr 7 -> bank_sel=1, rd_addr1=2'b11 gives 8'h3C; bank_sel=0 gives the addr 3 contents.
- Fill all 8 registers, pulse clr_req -> busy=1 for exactly 8 cycles, clr_done pulses once, then all reads return 0. A wr_en issued mid-sweep gives no ack and no update.
- clr_req and a write of 8'hFF to addr 5 on the same edge -> wr_ack=1 next cycle; after the sweep, addr 5 reads 0.
- Assert reset 3 cycles into a sweep -> busy=0 immediately, clr_done never pulses, all reads 0. With REG_BANK_BYPASS_EN defined, a write of 8'h11 to addr 2 with rd_addr2=2 -> rd_data2=8'h11 in the same cycle.
